// File: rtl/motor_cmd_pkg.sv
// motor_cmd_pkg: shared state encoding, fault cause codes and level width for the motor supervisor
package motor_cmd_pkg;
  localparam int LEVEL_W = 3;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    BRAKE    = 3'd2,
    FAULT    = 3'd3,
    COOLDOWN = 3'd4
  } state_t;
  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_OC    = 2'b01;
  localparam logic [1:0] FC_OT    = 2'b10;
  localparam logic [1:0] FC_MOTOR = 2'b11;
endpackage

// File: rtl/motor_cmd_supervisor_debounce.sv
// flag_debounce: asserts stable the cycle after raw has been high for CYCLES consecutive samples
module flag_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      cnt    <= !raw ? '0 : (cnt == W'(CYCLES)) ? cnt : cnt + W'(1);
      stable <= raw && (cnt >= W'(CYCLES - 1));
    end
  end
endmodule

// File: rtl/motor_cmd_supervisor.sv
// motor_cmd_supervisor: rate-limits speed requests, handles brake, latches debounced faults with cooldown
module motor_cmd_supervisor
  import motor_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RAMP_CYCLES     = 100,
  parameter int COOLDOWN_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LEVEL_W-1:0] req_level,
  input  logic               brake,
  input  logic               overcurrent,
  input  logic               overtemp,
  input  logic               motor_fault_fb,
  input  logic               fault_clear,
  output logic [LEVEL_W-1:0] psw,
  output logic               fault_in,
  output logic [2:0]         state,
  output logic [1:0]         fault_code
);
  localparam int RW = $clog2(RAMP_CYCLES + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  state_t cur, nxt;
  logic [LEVEL_W-1:0] psw_n;
  logic [RW-1:0] ramp, ramp_n;
  logic [CW-1:0] cool, cool_n;
  logic fin_n, oc_q, ot_q, fault_det;
  logic [1:0] fc_n, cause;
  flag_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_oc (.clk(clk), .rst_n(rst_n), .raw(overcurrent), .stable(oc_q));
  flag_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_ot (.clk(clk), .rst_n(rst_n), .raw(overtemp), .stable(ot_q));
  assign fault_det = oc_q | ot_q | motor_fault_fb;
  assign cause     = oc_q ? FC_OC : motor_fault_fb ? FC_MOTOR : FC_OT;
  assign state     = cur;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur        <= IDLE;
      psw        <= '0;
      fault_in   <= 1'b0;
      fault_code <= FC_NONE;
      ramp       <= '0;
      cool       <= '0;
    end else begin
      cur        <= nxt;
      psw        <= psw_n;
      fault_in   <= fin_n;
      fault_code <= fc_n;
      ramp       <= ramp_n;
      cool       <= cool_n;
    end
  end
  // FAULT keeps its first cause, so only non-FAULT states take the fault override
  always_comb begin
    nxt    = cur;
    psw_n  = psw;
    fin_n  = fault_in;
    fc_n   = fault_code;
    ramp_n = ramp;
    cool_n = cool;
    if (cur != FAULT && fault_det) begin
      nxt    = FAULT;
      psw_n  = '0;
      fin_n  = 1'b1;
      fc_n   = cause;
      ramp_n = '0;
      cool_n = '0;
    end else begin
      case (cur)
        IDLE: begin
          psw_n  = '0;
          ramp_n = '0;
          nxt    = brake ? BRAKE : (req_level != '0) ? RUN : IDLE;
        end
        RUN: begin
          if (brake) begin
            nxt    = BRAKE;
            psw_n  = '0;
            ramp_n = '0;
          end else if (psw == req_level) begin
            ramp_n = '0;
            nxt    = (psw == '0) ? IDLE : RUN;
          end else if (ramp == RW'(RAMP_CYCLES - 1)) begin
            ramp_n = '0;
            psw_n  = (req_level > psw) ? psw + LEVEL_W'(1) : psw - LEVEL_W'(1);
          end else begin
            ramp_n = ramp + RW'(1);
          end
        end
        BRAKE: begin
          psw_n = '0;
          nxt   = brake ? BRAKE : IDLE;
        end
        FAULT: begin
          psw_n = '0;
          fin_n = 1'b1;
          if (fault_clear && !fault_det) begin
            nxt    = COOLDOWN;
            fin_n  = 1'b0;
            cool_n = '0;
          end
        end
        COOLDOWN: begin
          psw_n = '0;
          fin_n = 1'b0;
          if (cool == CW'(COOLDOWN_CYCLES - 1)) begin
            nxt    = IDLE;
            fc_n   = FC_NONE;
            cool_n = '0;
          end else begin
            cool_n = cool + CW'(1);
          end
        end
        default: begin
          nxt   = IDLE;
          psw_n = '0;
          fin_n = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_motor_cmd_supervisor.sv
// tb_motor_cmd_supervisor: directed vectors with hand-computed expectations for the motor supervisor
module tb_motor_cmd_supervisor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req_level = '0;
  logic brake = 1'b0, overcurrent = 1'b0, overtemp = 1'b0, motor_fault_fb = 1'b0, fault_clear = 1'b0;
  logic [2:0] psw, state;
  logic fault_in;
  logic [1:0] fault_code;
  int total = 0;
  int bad = 0;
  motor_cmd_supervisor #(.DEBOUNCE_CYCLES(4), .RAMP_CYCLES(10), .COOLDOWN_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .req_level(req_level), .brake(brake), .overcurrent(overcurrent),
    .overtemp(overtemp), .motor_fault_fb(motor_fault_fb), .fault_clear(fault_clear),
    .psw(psw), .fault_in(fault_in), .state(state), .fault_code(fault_code)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  initial begin
    step(2);
    chk("rst_state", state, 0);
    chk("rst_psw", psw, 0);
    chk("rst_fault_in", fault_in, 0);
    chk("rst_code", fault_code, 0);
    rst_n = 1'b1;
    req_level = 3'd3;
    step(1);
    chk("s1_run", state, 1);
    step(9);
    chk("s1_psw_pre", psw, 0);
    step(1);
    chk("s1_psw1", psw, 1);
    step(10);
    chk("s1_psw2", psw, 2);
    step(10);
    chk("s1_psw3", psw, 3);
    step(20);
    chk("s1_hold", psw, 3);
    req_level = 3'd0;
    step(10);
    chk("s1_dn2", psw, 2);
    step(10);
    chk("s1_dn1", psw, 1);
    step(10);
    chk("s1_dn0", psw, 0);
    step(1);
    chk("s1_idle", state, 0);
    req_level = 3'd5;
    step(51);
    chk("s2_psw5", psw, 5);
    brake = 1'b1;
    step(1);
    chk("s2_brake_psw", psw, 0);
    chk("s2_brake_st", state, 2);
    step(19);
    brake = 1'b0;
    step(1);
    chk("s2_idle", state, 0);
    step(1);
    chk("s2_rerun", state, 1);
    step(9);
    chk("s2_psw_pre", psw, 0);
    step(1);
    chk("s2_psw1", psw, 1);
    brake = 1'b1;
    req_level = 3'd0;
    step(1);
    brake = 1'b0;
    step(1);
    chk("s3_idle", state, 0);
    overcurrent = 1'b1;
    step(3);
    overcurrent = 1'b0;
    step(3);
    chk("s3_short_st", state, 0);
    chk("s3_short_fi", fault_in, 0);
    overcurrent = 1'b1;
    step(4);
    chk("s3_qual_st", state, 0);
    step(1);
    chk("s3_fault_st", state, 3);
    chk("s3_fault_psw", psw, 0);
    chk("s3_fault_fi", fault_in, 1);
    chk("s3_fault_code", fault_code, 1);
    overcurrent = 1'b0;
    overtemp = 1'b1;
    step(5);
    chk("s4_code_held", fault_code, 1);
    fault_clear = 1'b1;
    step(3);
    chk("s4_ignored", state, 3);
    fault_clear = 1'b0;
    overtemp = 1'b0;
    step(2);
    fault_clear = 1'b1;
    step(1);
    fault_clear = 1'b0;
    chk("s4_cool_st", state, 4);
    chk("s4_cool_fi", fault_in, 0);
    chk("s4_cool_code", fault_code, 1);
    step(49);
    chk("s4_cool_end", state, 4);
    step(1);
    chk("s4_idle", state, 0);
    chk("s4_code_clr", fault_code, 0);
    overcurrent = 1'b1;
    step(4);
    motor_fault_fb = 1'b1;
    step(1);
    chk("s5_both_st", state, 3);
    chk("s5_both_code", fault_code, 1);
    overcurrent = 1'b0;
    motor_fault_fb = 1'b0;
    step(2);
    fault_clear = 1'b1;
    step(1);
    fault_clear = 1'b0;
    chk("s5_cool", state, 4);
    step(10);
    motor_fault_fb = 1'b1;
    step(1);
    chk("s5_refault_st", state, 3);
    chk("s5_refault_code", fault_code, 3);
    chk("s5_refault_fi", fault_in, 1);
    motor_fault_fb = 1'b0;
    step(1);
    fault_clear = 1'b1;
    step(1);
    fault_clear = 1'b0;
    step(49);
    chk("s5_cool_restart", state, 4);
    step(1);
    chk("s5_idle", state, 0);
    req_level = 3'd4;
    step(41);
    chk("s6_psw4", psw, 4);
    req_level = 3'd6;
    step(5);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("s6_rst_psw", psw, 0);
    chk("s6_rst_st", state, 0);
    chk("s6_rst_fi", fault_in, 0);
    step(1);
    chk("s6_run", state, 1);
    step(9);
    chk("s6_psw_pre", psw, 0);
    step(1);
    chk("s6_psw1", psw, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
